// File: rtl/vip_ctrl_pkg.sv
// Shared constants and types for the video control-packet generator.
package vip_ctrl_pkg;

  localparam logic [2:0] REG_GO        = 3'd0;
  localparam logic [2:0] REG_STATUS    = 3'd1;
  localparam logic [2:0] REG_WIDTH     = 3'd2;
  localparam logic [2:0] REG_HEIGHT    = 3'd3;
  localparam logic [2:0] REG_INTERLACE = 3'd4;
  localparam logic [2:0] REG_IRQ       = 3'd5;

  localparam logic [3:0]  PKT_TYPE_CTRL = 4'hF;
  localparam int unsigned NIBBLE_COUNT  = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2
  } state_t;

endpackage

// File: rtl/vip_ctrl_regs.sv
// Avalon-MM register file: go bit, frame shadows, registered read mux.
// Optional interrupt logic under VIP_CTRL_PACKET_GEN_IRQ_EN.
module vip_ctrl_regs
  import vip_ctrl_pkg::*;
#(
  parameter int unsigned DEF_WIDTH     = 1920,
  parameter int unsigned DEF_HEIGHT    = 1080,
  parameter int unsigned DEF_INTERLACE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  slave_addr,
  input  logic        slave_write,
  input  logic        slave_read,
  input  logic [31:0] slave_writedata,
  output logic [31:0] slave_readdata,
  input  logic        busy,
`ifdef VIP_CTRL_PACKET_GEN_IRQ_EN
  input  logic        irq_set,
  output logic        irq,
`endif
  output logic        go,
  output logic        go_rise_c,
  output logic        go_clr_c,
  output logic [15:0] shadow_width,
  output logic [15:0] shadow_height,
  output logic [3:0]  shadow_interlace
);

  logic [31:0] rd_mux_c;
  logic        status_irq_c;
  logic        wdata_unused;

  assign wdata_unused = ^slave_writedata[31:16];

  assign go_rise_c = slave_write && (slave_addr == REG_GO) && slave_writedata[0] && !go;
  assign go_clr_c  = slave_write && (slave_addr == REG_GO) && !slave_writedata[0];

  // Go bit and shadow registers; active copies live in the top level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      go               <= 1'b0;
      shadow_width     <= 16'(DEF_WIDTH);
      shadow_height    <= 16'(DEF_HEIGHT);
      shadow_interlace <= 4'(DEF_INTERLACE);
    end else if (slave_write) begin
      case (slave_addr)
        REG_GO:        go               <= slave_writedata[0];
        REG_WIDTH:     shadow_width     <= slave_writedata[15:0];
        REG_HEIGHT:    shadow_height    <= slave_writedata[15:0];
        REG_INTERLACE: shadow_interlace <= slave_writedata[3:0];
        default: ;
      endcase
    end
  end

`ifdef VIP_CTRL_PACKET_GEN_IRQ_EN
  logic irq_en;
  logic irq_pending;
  logic irq_en_n;
  logic irq_pend_n;

  // Set on last-beat accept wins over a simultaneous clear
  always_comb begin
    irq_en_n   = irq_en;
    irq_pend_n = irq_pending;
    if (slave_write && (slave_addr == REG_IRQ)) begin
      irq_en_n = slave_writedata[0];
      if (slave_writedata[1]) irq_pend_n = 1'b0;
    end
    if (irq_set) irq_pend_n = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en      <= 1'b0;
      irq_pending <= 1'b0;
      irq         <= 1'b0;
    end else begin
      irq_en      <= irq_en_n;
      irq_pending <= irq_pend_n;
      irq         <= irq_en_n & irq_pend_n;
    end
  end

  assign status_irq_c = irq_pending;
`else
  assign status_irq_c = 1'b0;
`endif

  always_comb begin
    rd_mux_c = '0;
    case (slave_addr)
      REG_GO:        rd_mux_c = {31'b0, go};
      REG_STATUS:    rd_mux_c = {29'b0, status_irq_c, busy, go};
      REG_WIDTH:     rd_mux_c = {16'b0, shadow_width};
      REG_HEIGHT:    rd_mux_c = {16'b0, shadow_height};
      REG_INTERLACE: rd_mux_c = {28'b0, shadow_interlace};
`ifdef VIP_CTRL_PACKET_GEN_IRQ_EN
      REG_IRQ:       rd_mux_c = {30'b0, irq_pending, irq_en};
`endif
      default:       rd_mux_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             slave_readdata <= '0;
    else if (slave_read) slave_readdata <= rd_mux_c;
  end

endmodule

// File: rtl/vip_ctrl_packet_gen.sv
// Avalon-ST control-packet generator: header beat plus packed frame-size nibbles.
// Define VIP_CTRL_PACKET_GEN_IRQ_EN to add the irq output and register 5.
module vip_ctrl_packet_gen
  import vip_ctrl_pkg::*;
#(
  parameter int unsigned BPS           = 8,
  parameter int unsigned SPB           = 3,
  parameter int unsigned DEF_WIDTH     = 1920,
  parameter int unsigned DEF_HEIGHT    = 1080,
  parameter int unsigned DEF_INTERLACE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         slave_addr,
  input  logic               slave_write,
  input  logic               slave_read,
  input  logic [31:0]        slave_writedata,
  output logic [31:0]        slave_readdata,
  input  logic               frame_start,
  output logic [BPS*SPB-1:0] source_data,
  output logic               source_valid,
  input  logic               source_ready,
  output logic               source_sop,
  output logic               source_eop,
  output logic [15:0]        width,
  output logic [15:0]        height,
  output logic [3:0]         interlace,
`ifdef VIP_CTRL_PACKET_GEN_IRQ_EN
  output logic               irq,
`endif
  output logic               go,
  output logic               busy
);

  localparam int unsigned DATA_W    = BPS * SPB;
  localparam int unsigned NUM_BEATS = (NIBBLE_COUNT + SPB - 1) / SPB;
  localparam int unsigned BEAT_W    = 4;
  localparam int unsigned PACK_W    = NUM_BEATS * SPB * 4;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  state_t              state, state_n;
  logic [BEAT_W-1:0]   beat, beat_n;
  logic                pending, pend_n;
  logic                commit_c, last_acc_c, accept_c, trigger_c;
  logic                go_rise_c, go_clr_c;
  logic [15:0]         shadow_width, shadow_height;
  logic [3:0]          shadow_interlace;
  logic [DATA_W-1:0]   data_n;
  logic [PACK_W-1:0]   nib_pad_c, nib_shift_c;

  vip_ctrl_regs #(
    .DEF_WIDTH     (DEF_WIDTH),
    .DEF_HEIGHT    (DEF_HEIGHT),
    .DEF_INTERLACE (DEF_INTERLACE)
  ) u_regs (
    .clk              (clk),
    .rst              (rst),
    .slave_addr       (slave_addr),
    .slave_write      (slave_write),
    .slave_read       (slave_read),
    .slave_writedata  (slave_writedata),
    .slave_readdata   (slave_readdata),
    .busy             (busy),
`ifdef VIP_CTRL_PACKET_GEN_IRQ_EN
    .irq_set          (last_acc_c),
    .irq              (irq),
`endif
    .go               (go),
    .go_rise_c        (go_rise_c),
    .go_clr_c         (go_clr_c),
    .shadow_width     (shadow_width),
    .shadow_height    (shadow_height),
    .shadow_interlace (shadow_interlace)
  );

  assign accept_c  = source_valid & source_ready;
  assign trigger_c = go_rise_c | (frame_start & go);

  // Next state, beat counter and one-deep pending trigger
  always_comb begin
    state_n    = state;
    beat_n     = beat;
    pend_n     = pending;
    commit_c   = 1'b0;
    last_acc_c = 1'b0;
    if (go_clr_c)                           pend_n = 1'b0;
    else if (trigger_c && state != ST_IDLE) pend_n = 1'b1;
    case (state)
      ST_IDLE: begin
        if (trigger_c) begin
          state_n  = ST_HDR;
          beat_n   = '0;
          commit_c = 1'b1;
        end
      end
      ST_HDR: begin
        if (accept_c) begin
          state_n = ST_BODY;
          beat_n  = '0;
        end
      end
      ST_BODY: begin
        if (accept_c) begin
          if (beat == LAST_BEAT) begin
            last_acc_c = 1'b1;
            // A pending trigger is consumed; one arriving this same cycle re-arms it
            if ((pending || trigger_c) && !go_clr_c) begin
              state_n  = ST_HDR;
              beat_n   = '0;
              commit_c = 1'b1;
              pend_n   = pending & trigger_c;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            beat_n = beat + BEAT_W'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Nibble 0 (width[15:12]) sits at the LSBs so each beat is a plain right shift
  assign nib_pad_c = PACK_W'({interlace,
                              height[3:0], height[7:4], height[11:8], height[15:12],
                              width[3:0],  width[7:4],  width[11:8],  width[15:12]});
  assign nib_shift_c = nib_pad_c >> (32'(beat_n) * (SPB * 4));

  always_comb begin
    data_n = '0;
    if (state_n == ST_HDR) begin
      data_n[3:0] = PKT_TYPE_CTRL;
    end else if (state_n == ST_BODY) begin
      for (int s = 0; s < int'(SPB); s++) begin
        data_n[s*BPS +: 4] = nib_shift_c[s*4 +: 4];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      beat         <= '0;
      pending      <= 1'b0;
      busy         <= 1'b0;
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_data  <= '0;
    end else begin
      state        <= state_n;
      beat         <= beat_n;
      pending      <= pend_n;
      busy         <= (state_n != ST_IDLE);
      source_valid <= (state_n != ST_IDLE);
      source_sop   <= (state_n == ST_HDR);
      source_eop   <= (state_n == ST_BODY) && (beat_n == LAST_BEAT);
      source_data  <= data_n;
    end
  end

  // Shadow values become active only when a header is about to be emitted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width     <= 16'(DEF_WIDTH);
      height    <= 16'(DEF_HEIGHT);
      interlace <= 4'(DEF_INTERLACE);
    end else if (commit_c) begin
      width     <= shadow_width;
      height    <= shadow_height;
      interlace <= shadow_interlace;
    end
  end

endmodule

// File: tb/tb_vip_ctrl_packet_gen.sv
// Directed self-checking bench: default (SPB=3) and SPB=1 instances share stimulus.
module tb_vip_ctrl_packet_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  addr = '0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [31:0] wdata = '0;
  logic        frame_start = 1'b0;
  logic        ready = 1'b1;

  logic [31:0] a_rdata, b_rdata;
  logic [23:0] a_data;
  logic [7:0]  b_data;
  logic        a_valid, a_sop, a_eop, a_go, a_busy;
  logic        b_valid, b_sop, b_eop, b_go, b_busy;
  logic [15:0] a_width, a_height, b_width, b_height;
  logic [3:0]  a_il, b_il;
`ifdef VIP_CTRL_PACKET_GEN_IRQ_EN
  logic        a_irq, b_irq;
`endif

  int tests = 0;
  int fails = 0;

  logic [33:0] qa[$];
  logic [33:0] qb[$];
  logic        pa_valid = 1'b0, pa_ready = 1'b0, pa_busy = 1'b0;
  logic [25:0] pa_beat = '0;
  int          stall_bad = 0, stall_seen = 0, busy_falls = 0;

  always #5 clk = ~clk;

  vip_ctrl_packet_gen dut_a (
    .clk(clk), .rst(rst),
    .slave_addr(addr), .slave_write(write), .slave_read(read),
    .slave_writedata(wdata), .slave_readdata(a_rdata),
    .frame_start(frame_start),
    .source_data(a_data), .source_valid(a_valid), .source_ready(ready),
    .source_sop(a_sop), .source_eop(a_eop),
    .width(a_width), .height(a_height), .interlace(a_il),
`ifdef VIP_CTRL_PACKET_GEN_IRQ_EN
    .irq(a_irq),
`endif
    .go(a_go), .busy(a_busy)
  );

  vip_ctrl_packet_gen #(.SPB(1)) dut_b (
    .clk(clk), .rst(rst),
    .slave_addr(addr), .slave_write(write), .slave_read(read),
    .slave_writedata(wdata), .slave_readdata(b_rdata),
    .frame_start(frame_start),
    .source_data(b_data), .source_valid(b_valid), .source_ready(ready),
    .source_sop(b_sop), .source_eop(b_eop),
    .width(b_width), .height(b_height), .interlace(b_il),
`ifdef VIP_CTRL_PACKET_GEN_IRQ_EN
    .irq(b_irq),
`endif
    .go(b_go), .busy(b_busy)
  );

  // Capture accepted beats and watch stall stability / busy drops
  always @(posedge clk) begin
    if (a_valid && ready) qa.push_back({a_sop, a_eop, 32'(a_data)});
    if (b_valid && ready) qb.push_back({b_sop, b_eop, 32'(b_data)});
    if (pa_valid && !pa_ready && a_valid && ({a_sop, a_eop, a_data} !== pa_beat))
      stall_bad <= stall_bad + 1;
    if (a_valid && !ready) stall_seen <= stall_seen + 1;
    if (pa_busy && !a_busy) busy_falls <= busy_falls + 1;
    pa_valid <= a_valid;
    pa_ready <= ready;
    pa_beat  <= {a_sop, a_eop, a_data};
    pa_busy  <= a_busy;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input int idx, input logic s, input logic e,
                         input logic [31:0] d);
    check(tag, 64'(qa[idx]), 64'({s, e, d}));
  endtask

  task automatic check_b(input string tag, input int idx, input logic s, input logic e,
                         input logic [31:0] d);
    check(tag, 64'(qb[idx]), 64'({s, e, d}));
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = a_rdata;
  endtask

  task automatic pulse_fs();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while ((a_busy || b_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(a_busy | b_busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdv;
    int          base, bbase, sb0, ss0, bf0;
    logic [7:0]  exp_b [10] = '{8'h0F, 8'h00, 8'h02, 8'h08, 8'h00,
                                8'h00, 8'h01, 8'h0E, 8'h00, 8'h00};

    // Reset state
    #12;
    check("rst_valid", 64'(a_valid), 64'd0);
    check("rst_data",  64'(a_data), 64'd0);
    check("rst_go",    64'(a_go), 64'd0);
    check("rst_busy",  64'(a_busy), 64'd0);
    check("rst_width", 64'(a_width), 64'd1920);
    check("rst_height", 64'(a_height), 64'd1080);
    check("rst_rdata", 64'(a_rdata), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    rd(3'd2, rdv); check("rd_width_def", 64'(rdv), 64'h780);
    rd(3'd1, rdv); check("rd_status_idle", 64'(rdv), 64'd0);
    rd(3'd7, rdv); check("rd_unmapped", 64'(rdv), 64'd0);

    // Go 0->1 launches one packet at 1920x1080
    base = qa.size();
    wr(3'd0, 32'd1);
    check("go_hdr_sop",  64'(a_sop), 64'd1);
    check("go_hdr_data", 64'(a_data), 64'h00000F);
    check("go_busy",     64'(a_busy), 64'd1);
    wait_idle("go_idle");
    check("go_len", 64'(qa.size() - base), 64'd4);
    check_a("go_b0", base + 0, 1'b1, 1'b0, 32'h00000F);
    check_a("go_b1", base + 1, 1'b0, 1'b0, 32'h080700);
    check_a("go_b2", base + 2, 1'b0, 1'b0, 32'h040000);
    check_a("go_b3", base + 3, 1'b0, 1'b1, 32'h000803);
    rd(3'd1, rdv); check("rd_status_go", 64'(rdv), 64'd1);

    // 640x480: shadows only until the next header, then SPB=1 ten-beat packet
    wr(3'd2, 32'd640);
    wr(3'd3, 32'd480);
    check("shadow_not_active", 64'(a_width), 64'd1920);
    rd(3'd2, rdv); check("rd_width_640", 64'(rdv), 64'h280);
    base = qa.size();
    bbase = qb.size();
    pulse_fs();
    wait_idle("fs640_idle");
    check("fs640_width", 64'(a_width), 64'd640);
    check("fs640_blen", 64'(qb.size() - bbase), 64'd10);
    for (int i = 0; i < 10; i++)
      check_b("spb1_beat", bbase + i, (i == 0), (i == 9), 32'(exp_b[i]));
    check_a("a640_b1", base + 1, 1'b0, 1'b0, 32'h080200);
    check_a("a640_b2", base + 2, 1'b0, 1'b0, 32'h010000);
    check_a("a640_b3", base + 3, 1'b0, 1'b1, 32'h00000E);

    // Ready toggling: stable while stalled, same beats as the unstalled packet
    wr(3'd2, 32'd1920);
    wr(3'd3, 32'd1080);
    base = qa.size();
    sb0 = stall_bad;
    ss0 = stall_seen;
    pulse_fs();
    for (int i = 0; i < 200 && (a_busy || b_busy); i++) begin
      ready = ~ready;
      @(negedge clk);
    end
    ready = 1'b1;
    check("tog_idle", 64'(a_busy | b_busy), 64'd0);
    check("tog_stable", 64'(stall_bad - sb0), 64'd0);
    check("tog_stalled", 64'(stall_seen > ss0), 64'd1);
    check("tog_len", 64'(qa.size() - base), 64'd4);
    check_a("tog_b0", base + 0, 1'b1, 1'b0, 32'h00000F);
    check_a("tog_b1", base + 1, 1'b0, 1'b0, 32'h080700);
    check_a("tog_b2", base + 2, 1'b0, 1'b0, 32'h040000);
    check_a("tog_b3", base + 3, 1'b0, 1'b1, 32'h000803);

    // Width/interlace written mid-packet apply only to the next packet
    base = qa.size();
    pulse_fs();
    wr(3'd2, 32'd800);
    wr(3'd4, 32'd3);
    wait_idle("mid_idle");
    check("mid_width_old", 64'(a_width), 64'd1920);
    check_a("mid_b1_old", base + 1, 1'b0, 1'b0, 32'h080700);
    rd(3'd2, rdv); check("rd_width_800", 64'(rdv), 64'h320);
    base = qa.size();
    pulse_fs();
    wait_idle("next_idle");
    check("next_width", 64'(a_width), 64'd800);
    check("next_il", 64'(a_il), 64'd3);
    check_a("next_b1", base + 1, 1'b0, 1'b0, 32'h020300);
    check_a("next_b3", base + 3, 1'b0, 1'b1, 32'h030803);

    // Two triggers during one (stalled) packet -> exactly one back-to-back packet
    base = qa.size();
    bbase = qb.size();
    bf0 = busy_falls;
    pulse_fs();
    ready = 1'b0;
    pulse_fs();
    pulse_fs();
    ready = 1'b1;
    wait_idle("pend_idle");
    check("pend_len", 64'(qa.size() - base), 64'd8);
    check("pend_blen", 64'(qb.size() - bbase), 64'd20);
    check_a("pend_hdr2", base + 4, 1'b1, 1'b0, 32'h00000F);
    check("pend_b2b", 64'(busy_falls - bf0), 64'd1);

    // Reset mid-packet drops valid immediately and does not resume
    pulse_fs();
    @(negedge clk);
    check("pre_rst_valid", 64'(a_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 64'(a_valid), 64'd0);
    check("rst_mid_busy", 64'(a_busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_valid", 64'(a_valid | b_valid), 64'd0);
    check("post_rst_width", 64'(a_width), 64'd1920);
    check("post_rst_go", 64'(a_go), 64'd0);

    // Clearing go mid-packet finishes the packet but drops the pending trigger
    base = qa.size();
    wr(3'd0, 32'd1);
    pulse_fs();
    wr(3'd0, 32'd0);
    wait_idle("goclr_idle");
    repeat (3) @(negedge clk);
    check("goclr_len", 64'(qa.size() - base), 64'd4);
    check("goclr_eop", 64'(qa[base + 3][32]), 64'd1);
    check("goclr_busy", 64'(a_busy), 64'd0);
    check("goclr_go", 64'(a_go), 64'd0);

`ifdef VIP_CTRL_PACKET_GEN_IRQ_EN
    wr(3'd5, 32'h2);
    check("irq_clr0", 64'(a_irq), 64'd0);
    rd(3'd5, rdv); check("rd_irq_clr", 64'(rdv), 64'd0);
    wr(3'd5, 32'h1);
    check("irq_en_nopend", 64'(a_irq), 64'd0);
    wr(3'd0, 32'd1);
    wait_idle("irq_idle");
    check("irq_set", 64'(a_irq), 64'd1);
    rd(3'd5, rdv); check("rd_irq_set", 64'(rdv), 64'h3);
    rd(3'd1, rdv); check("rd_status_irq", 64'(rdv), 64'h5);
    wr(3'd5, 32'h2);
    check("irq_clear", 64'(a_irq), 64'd0);
`else
    rd(3'd5, rdv); check("rd_reg5_zero", 64'(rdv), 64'd0);
    rd(3'd1, rdv); check("rd_status_noirq", 64'(rdv), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
